// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the phased ALU control decoder: aluOp classes, ALU
// operation codes, funct7 patterns and the base funct3 -> operation mapping.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      ALUOP_MEM = 2'b00,
      ALUOP_BR  = 2'b01,
      ALUOP_R   = 2'b10,
      ALUOP_I   = 2'b11
   } aluop_e;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_MUL  = 4'b1010;
   localparam logic [3:0] ALU_MULH = 4'b1011;
   localparam logic [3:0] ALU_DIV  = 4'b1100;
   localparam logic [3:0] ALU_REM  = 4'b1101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   typedef struct packed {
      logic [3:0] code;
      logic       illegal;
   } decode_t;

   // Operation selected by funct3 alone (funct7 = base pattern).
   function automatic logic [3:0] base_op(input logic [2:0] f3);
      logic [3:0] op;
      op = ALU_ADD;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_phase_counter.sv
// Instruction-step phase counter: counts 0..PHASES-1 and wraps, frozen by stall,
// with strobes marking the capture, decode and last phases.
module alu_phase_counter
   import alu_ctrl_pkg::*;
#(
   parameter int PHASES       = 10,
   parameter int DECODE_PHASE = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      stall,
   output logic [$clog2(PHASES)-1:0] phase,
   output logic                      is_capture,
   output logic                      is_decode,
   output logic                      is_last
);

   localparam int PW = $clog2(PHASES);

   assign is_capture = (phase == PW'(DECODE_PHASE - 1));
   assign is_decode  = (phase == PW'(DECODE_PHASE));
   assign is_last    = (phase == PW'(PHASES - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset)
         phase <= '0;
      else if (!stall)
         phase <= is_last ? '0 : phase + PW'(1);
   end

endmodule

// File: rtl/alu_control_phased.sv
// Phased ALU control decoder: captures aluOp/funct3/funct7 one phase before decode
// and registers the ALU code. Optional M-extension decode under ALU_CTRL_MEXT_EN.
module alu_control_phased
   import alu_ctrl_pkg::*;
#(
   parameter int PHASES       = 10,
   parameter int DECODE_PHASE = 4,
   parameter int CTRL_W       = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      stall,
   input  logic [1:0]                aluOp,
   input  logic [2:0]                funct3,
   input  logic [6:0]                funct7,
   output logic [CTRL_W-1:0]         alu_ctrl,
   output logic                      ctrl_valid,
   output logic                      illegal,
   output logic [$clog2(PHASES)-1:0] phase
);

   logic       is_capture;
   logic       is_decode;
   logic       is_last;
   logic [1:0] cap_op;
   logic [2:0] cap_f3;
   logic [6:0] cap_f7;
   decode_t    dec;

   alu_phase_counter #(
      .PHASES       (PHASES),
      .DECODE_PHASE (DECODE_PHASE)
   ) u_phase (
      .clock      (clock),
      .reset      (reset),
      .stall      (stall),
      .phase      (phase),
      .is_capture (is_capture),
      .is_decode  (is_decode),
      .is_last    (is_last)
   );

   function automatic decode_t decode(input logic [1:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
      decode_t d;
      d.code    = ALU_ADD;
      d.illegal = 1'b0;
      case (op)
         ALUOP_MEM: d.code = ALU_ADD;
         ALUOP_BR:  d.code = ALU_SUB;
         ALUOP_I: begin
            d.code = base_op(f3);
            if (f3 == 3'b001 && f7 != F7_BASE)
               d.illegal = 1'b1;
            else if (f3 == 3'b101 && f7 == F7_ALT)
               d.code = ALU_SRA;
            else if (f3 == 3'b101 && f7 != F7_BASE)
               d.illegal = 1'b1;
         end
         default: begin
            if (f7 == F7_BASE)
               d.code = base_op(f3);
            else if (f7 == F7_ALT && f3 == 3'b000)
               d.code = ALU_SUB;
            else if (f7 == F7_ALT && f3 == 3'b101)
               d.code = ALU_SRA;
`ifdef ALU_CTRL_MEXT_EN
            else if (f7 == F7_MEXT) begin
               case (f3)
                  3'b000:  d.code = ALU_MUL;
                  3'b001:  d.code = ALU_MULH;
                  3'b100:  d.code = ALU_DIV;
                  3'b110:  d.code = ALU_REM;
                  default: d.illegal = 1'b1;
               endcase
            end
`endif
            else
               d.illegal = 1'b1;
         end
      endcase
      // Unsupported encodings fall back to ADD so the datapath stays benign.
      if (d.illegal)
         d.code = ALU_ADD;
      return d;
   endfunction

   // NOTE: decode reads only the captured fields, never the live inputs.
   assign dec = decode(cap_op, cap_f3, cap_f7);

   always_ff @(posedge clock) begin
      if (reset) begin
         cap_op     <= '0;
         cap_f3     <= '0;
         cap_f7     <= '0;
         alu_ctrl   <= '0;
         ctrl_valid <= 1'b0;
         illegal    <= 1'b0;
      end else if (!stall) begin
         if (is_capture) begin
            cap_op <= aluOp;
            cap_f3 <= funct3;
            cap_f7 <= funct7;
         end
         if (is_decode) begin
            alu_ctrl   <= CTRL_W'(dec.code);
            illegal    <= dec.illegal;
            ctrl_valid <= 1'b1;
         end else if (is_last) begin
            ctrl_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_control_phased.sv
// Self-checking bench for alu_control_phased: directed scenarios plus random
// stimulus against a mnemonic-level reference model (honours ALU_CTRL_MEXT_EN).
module tb_alu_control_phased;

   localparam int P  = 10;
   localparam int DP = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       stall = 1'b0;
   logic [1:0] aluOp = '0;
   logic [2:0] funct3 = '0;
   logic [6:0] funct7 = '0;
   logic [3:0] alu_ctrl;
   logic       ctrl_valid;
   logic       illegal;
   logic [3:0] phase;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int         m_phase   = 0;
   logic [1:0] m_op      = '0;
   logic [2:0] m_f3      = '0;
   logic [6:0] m_f7      = '0;
   logic [3:0] m_ctrl    = '0;
   logic       m_illegal = 1'b0;
   logic       m_decoded = 1'b0;

   string base_names [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
   string mext_names [8] = '{"MUL", "MULH", "", "", "DIV", "", "REM", ""};

   alu_control_phased #(.PHASES(P), .DECODE_PHASE(DP), .CTRL_W(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .stall      (stall),
      .aluOp      (aluOp),
      .funct3     (funct3),
      .funct7     (funct7),
      .alu_ctrl   (alu_ctrl),
      .ctrl_valid (ctrl_valid),
      .illegal    (illegal),
      .phase      (phase)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic string ref_name(input logic [1:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
      if (op == 2'b00) return "ADD";
      if (op == 2'b01) return "SUB";
      if (op == 2'b11) begin
         if (f3 == 3'd1) return (f7 == 7'h00) ? "SLL" : "ILLEGAL";
         if (f3 == 3'd5) return (f7 == 7'h00) ? "SRL" : (f7 == 7'h20) ? "SRA" : "ILLEGAL";
         return base_names[f3];
      end
      if (f7 == 7'h00) return base_names[f3];
      if (f7 == 7'h20 && f3 == 3'd0) return "SUB";
      if (f7 == 7'h20 && f3 == 3'd5) return "SRA";
`ifdef ALU_CTRL_MEXT_EN
      if (f7 == 7'h01 && mext_names[f3] != "") return mext_names[f3];
`endif
      return "ILLEGAL";
   endfunction

   function automatic logic [3:0] name_code(input string n);
      case (n)
         "AND":   return 4'd0;
         "OR":    return 4'd1;
         "XOR":   return 4'd3;
         "SLL":   return 4'd4;
         "SRL":   return 4'd5;
         "SUB":   return 4'd6;
         "SRA":   return 4'd7;
         "SLT":   return 4'd8;
         "SLTU":  return 4'd9;
         "MUL":   return 4'd10;
         "MULH":  return 4'd11;
         "DIV":   return 4'd12;
         "REM":   return 4'd13;
         default: return 4'd2;
      endcase
   endfunction

   task automatic model_edge(input logic rst, input logic stl, input logic [1:0] op,
                             input logic [2:0] f3, input logic [6:0] f7);
      string n;
      if (rst) begin
         m_phase = 0; m_op = '0; m_f3 = '0; m_f7 = '0;
         m_ctrl = '0; m_illegal = 1'b0; m_decoded = 1'b0;
      end else if (!stl) begin
         if (m_phase == DP - 1) begin
            m_op = op; m_f3 = f3; m_f7 = f7;
         end
         if (m_phase == DP) begin
            n = ref_name(m_op, m_f3, m_f7);
            m_ctrl    = name_code(n);
            m_illegal = (n == "ILLEGAL");
            m_decoded = 1'b1;
         end
         if (m_phase == P - 1) m_decoded = 1'b0;
         m_phase = (m_phase + 1) % P;
      end
   endtask

   task automatic step(input logic rst, input logic stl, input logic [1:0] op,
                       input logic [2:0] f3, input logic [6:0] f7);
      @(negedge clock);
      reset = rst; stall = stl; aluOp = op; funct3 = f3; funct7 = f7;
      @(posedge clock);
      #1;
      model_edge(rst, stl, op, f3, f7);
      check("phase", 32'(phase), 32'(m_phase));
      check("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
      check("ctrl_valid", 32'(ctrl_valid), 32'(m_decoded));
      check("illegal", 32'(illegal), 32'(m_illegal));
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 2'($urandom), 3'($urandom), 7'($urandom));
   endtask

   task automatic goto_phase(input int target);
      int budget = 3 * P;
      while (m_phase != target && budget > 0) begin
         idle_step();
         budget--;
      end
      if (budget == 0) check("goto_phase_budget", 32'(m_phase), 32'(target));
   endtask

   // Presents an instruction in the capture phase, changes inputs in the decode
   // phase, and returns with the model at phase DECODE_PHASE+1.
   task automatic run_instr(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
      goto_phase(DP - 1);
      step(1'b0, 1'b0, op, f3, f7);
      step(1'b0, 1'b0, 2'b00, 3'b111, 7'h7f);
   endtask

   initial begin
      logic [6:0] f7r;

      step(1'b1, 1'b0, 2'b10, 3'b101, 7'h20);
      step(1'b1, 1'b1, 2'b11, 3'b011, 7'h01);
      check("rst_ctrl", 32'(alu_ctrl), 32'd0);
      check("rst_valid", 32'(ctrl_valid), 32'd0);
      check("rst_phase", 32'(phase), 32'd0);

      for (int i = 1; i <= 20; i++) begin
         idle_step();
         check("walk_phase", 32'(phase), 32'(i % P));
         check("walk_valid", 32'(ctrl_valid), 32'((i % P) >= DP + 1));
      end

      run_instr(2'b10, 3'b000, 7'h20);
      check("sub_ctrl", 32'(alu_ctrl), 32'h6);
      check("sub_illegal", 32'(illegal), 32'd0);
      check("sub_phase", 32'(phase), 32'd5);

      run_instr(2'b11, 3'b101, 7'h20);
      check("srai_ctrl", 32'(alu_ctrl), 32'h7);
      run_instr(2'b11, 3'b101, 7'h00);
      check("srli_ctrl", 32'(alu_ctrl), 32'h5);

      run_instr(2'b10, 3'b000, 7'h01);
`ifdef ALU_CTRL_MEXT_EN
      check("mul_ctrl", 32'(alu_ctrl), 32'ha);
      check("mul_illegal", 32'(illegal), 32'd0);
`else
      check("mul_ctrl", 32'(alu_ctrl), 32'h2);
      check("mul_illegal", 32'(illegal), 32'd1);
`endif
      check("mul_valid", 32'(ctrl_valid), 32'd1);

      goto_phase(DP - 1);
      step(1'b0, 1'b0, 2'b10, 3'b101, 7'h20);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 2'b01, 3'b000, 7'h00);
         check("stall_phase", 32'(phase), 32'(DP));
      end
      step(1'b0, 1'b0, 2'b01, 3'b000, 7'h00);
      check("stall_decode", 32'(alu_ctrl), 32'h7);
      check("stall_phase_resume", 32'(phase), 32'(DP + 1));
      step(1'b1, 1'b1, 2'b00, 3'b000, 7'h00);
      check("rst_over_stall", 32'(phase), 32'd0);
      check("rst_over_stall_valid", 32'(ctrl_valid), 32'd0);

      run_instr(2'b10, 3'b100, 7'h00);
      check("xor_ctrl", 32'(alu_ctrl), 32'h3);
      goto_phase(7);
      check("mid_valid", 32'(ctrl_valid), 32'd1);
      step(1'b1, 1'b0, 2'b10, 3'b100, 7'h00);
      check("mid_rst_valid", 32'(ctrl_valid), 32'd0);
      check("mid_rst_ctrl", 32'(alu_ctrl), 32'd0);
      check("mid_rst_phase", 32'(phase), 32'd0);

      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       f7r = 7'h00;
            1:       f7r = 7'h20;
            2:       f7r = 7'h01;
            default: f7r = 7'($urandom);
         endcase
         step(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 20),
              2'($urandom), 3'($urandom), f7r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
